// File: rtl/poly_sequencer_if.sv
// Register-bus and poly_core signal bundle for poly_sequencer.
// The slave modport is the sequencer; the master modport is whoever drives the bus and hosts the core.
interface poly_sequencer_if;
  logic       cpu_wr;
  logic [3:0] cpu_addr;
  logic [7:0] cpu_din;
  logic       rnd_rd;
  logic [7:0] poly_rnd;
  logic       poly_enn;
  logic       poly_init;
  logic       poly_sel9;
  logic [7:0] rnd_data;
  logic       rnd_valid;
  logic       poly_ready;

  modport slave (
    input  cpu_wr, cpu_addr, cpu_din, rnd_rd, poly_rnd,
    output poly_enn, poly_init, poly_sel9, rnd_data, rnd_valid, poly_ready
  );

  modport master (
    output cpu_wr, cpu_addr, cpu_din, rnd_rd, poly_rnd,
    input  poly_enn, poly_init, poly_sel9, rnd_data, rnd_valid, poly_ready
  );
endinterface

// File: rtl/poly_sequencer.sv
// Sequencer for the POKEY poly counters: tick prescaler, SKCTL-driven init/flush FSM,
// tick-aligned 9-bit poly select and RANDOM register capture.
module poly_sequencer #(
  parameter int unsigned CLK_DIV     = 16,
  parameter int unsigned INIT_TICKS  = 17,
  parameter logic [3:0]  SKCTL_ADDR  = 4'hF,
  parameter logic [3:0]  AUDCTL_ADDR = 4'h8
) (
  input  logic              clk,
  input  logic              reset,
  poly_sequencer_if.slave   bus
);

  localparam int unsigned   PW         = $clog2(CLK_DIV);
  localparam int unsigned   TW         = $clog2(INIT_TICKS + 1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);
  localparam logic [TW-1:0] TICK_LAST  = TW'(INIT_TICKS - 1);

  typedef enum logic [1:0] {
    S_HOLD  = 2'd0,
    S_FLUSH = 2'd1,
    S_RUN   = 2'd2
  } state_e;

  state_e          state_q,    state_d;
  logic [PW-1:0]   presc_q,    presc_d;
  logic [TW-1:0]   tick_cnt_q, tick_cnt_d;
  logic            enn_q,      enn_d;
  logic            init_q,     init_d;
  logic            ready_q,    ready_d;
  logic            pend_q,     pend_d;
  logic            sel9_q,     sel9_d;
  logic [7:0]      rnd_data_q, rnd_data_d;
  logic            rnd_vld_q,  rnd_vld_d;

  logic            skctl_wr;
  logic            skctl_en;
  logic            audctl_wr;

  // Before the core is released the shift register holds garbage, so reads return all ones.
  function automatic logic [7:0] rnd_capture(input logic ready, input logic [7:0] rnd);
    return ready ? rnd : 8'hFF;
  endfunction

  assign skctl_wr  = bus.cpu_wr && (bus.cpu_addr == SKCTL_ADDR);
  assign skctl_en  = |bus.cpu_din[1:0];
  assign audctl_wr = bus.cpu_wr && (bus.cpu_addr == AUDCTL_ADDR);

  always_comb begin
    presc_d = presc_q + 1'b1;
    enn_d   = 1'b0;
    if (presc_q == PRESC_LAST) begin
      presc_d = '0;
      enn_d   = 1'b1;
    end
  end

  // An SKCTL write in FLUSH pre-empts any tick arriving in the same cycle.
  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    case (state_q)
      S_HOLD: begin
        if (skctl_wr && skctl_en) begin
          state_d    = S_FLUSH;
          tick_cnt_d = '0;
        end
      end
      S_FLUSH: begin
        if (skctl_wr) begin
          if (!skctl_en) begin
            state_d    = S_HOLD;
            tick_cnt_d = '0;
          end
        end else if (enn_q) begin
          tick_cnt_d = tick_cnt_q + 1'b1;
          if (tick_cnt_q == TICK_LAST) begin
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (skctl_wr && !skctl_en) begin
          state_d    = S_HOLD;
          tick_cnt_d = '0;
        end
      end
      default: begin
        state_d    = S_HOLD;
        tick_cnt_d = '0;
      end
    endcase
    init_d  = (state_d != S_RUN);
    ready_d = (state_d == S_RUN);
  end

  // sel9 changes on the same edge the core shifts, so it stays stable across a whole tick.
  always_comb begin
    pend_d = pend_q;
    sel9_d = sel9_q;
    if (audctl_wr) begin
      pend_d = bus.cpu_din[7];
    end
    if (enn_q) begin
      sel9_d = pend_q;
    end
  end

  always_comb begin
    rnd_data_d = rnd_data_q;
    rnd_vld_d  = 1'b0;
    if (bus.rnd_rd) begin
      rnd_data_d = rnd_capture(ready_q, bus.poly_rnd);
      rnd_vld_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q    <= '0;
      enn_q      <= 1'b0;
      state_q    <= S_HOLD;
      tick_cnt_q <= '0;
      init_q     <= 1'b1;
      ready_q    <= 1'b0;
      pend_q     <= 1'b0;
      sel9_q     <= 1'b0;
      rnd_data_q <= 8'h00;
      rnd_vld_q  <= 1'b0;
    end else begin
      presc_q    <= presc_d;
      enn_q      <= enn_d;
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      init_q     <= init_d;
      ready_q    <= ready_d;
      pend_q     <= pend_d;
      sel9_q     <= sel9_d;
      rnd_data_q <= rnd_data_d;
      rnd_vld_q  <= rnd_vld_d;
    end
  end

  assign bus.poly_enn   = enn_q;
  assign bus.poly_init  = init_q;
  assign bus.poly_sel9  = sel9_q;
  assign bus.rnd_data   = rnd_data_q;
  assign bus.rnd_valid  = rnd_vld_q;
  assign bus.poly_ready = ready_q;

endmodule

// File: tb/tb_poly_sequencer.sv
// Directed bench for poly_sequencer: a cycle-level model checked on every falling edge,
// plus literal expectations for the key timing points.
module tb_poly_sequencer;
  localparam int CLK_DIV    = 16;
  localparam int INIT_TICKS = 17;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   tests = 0;
  int   fails = 0;
  bit   cmp_en = 1'b0;

  poly_sequencer_if bus ();

  poly_sequencer #(
    .CLK_DIV    (CLK_DIV),
    .INIT_TICKS (INIT_TICKS),
    .SKCTL_ADDR (4'hF),
    .AUDCTL_ADDR(4'h8)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: mode 0=HOLD 1=FLUSH 2=RUN; ticks land every CLK_DIV cycles after reset release.
  int       m_cyc = 0;
  int       m_mode = 0;
  int       m_ticks = 0;
  bit       m_enn = 0;
  bit       m_pend = 0;
  bit       m_sel9 = 0;
  bit       m_rvld = 0;
  bit [7:0] m_rdata = 8'h00;

  always @(posedge clk) begin
    bit tick_now;
    bit was_run;
    bit sk;
    bit aud;
    if (reset) begin
      m_cyc = 0; m_mode = 0; m_ticks = 0; m_enn = 0;
      m_pend = 0; m_sel9 = 0; m_rvld = 0; m_rdata = 8'h00;
    end else begin
      tick_now = m_enn;
      was_run  = (m_mode == 2);
      sk  = bus.cpu_wr && bus.cpu_addr == 4'hF;
      aud = bus.cpu_wr && bus.cpu_addr == 4'h8;
      if (sk) begin
        if (bus.cpu_din[1:0] == 2'b00) begin
          m_mode = 0; m_ticks = 0;
        end else if (m_mode == 0) begin
          m_mode = 1; m_ticks = 0;
        end
      end else if (tick_now && m_mode == 1) begin
        m_ticks++;
        if (m_ticks == INIT_TICKS) m_mode = 2;
      end
      if (tick_now) m_sel9 = m_pend;
      if (aud) m_pend = bus.cpu_din[7];
      m_rvld = bus.rnd_rd;
      if (bus.rnd_rd) m_rdata = was_run ? bus.poly_rnd : 8'hFF;
      m_cyc++;
      m_enn = (m_cyc % CLK_DIV == 0);
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("enn",   {7'd0, bus.poly_enn},   {7'd0, m_enn});
      chk("init",  {7'd0, bus.poly_init},  {7'd0, m_mode != 2});
      chk("ready", {7'd0, bus.poly_ready}, {7'd0, m_mode == 2});
      chk("sel9",  {7'd0, bus.poly_sel9},  {7'd0, m_sel9});
      chk("rvld",  {7'd0, bus.rnd_valid},  {7'd0, m_rvld});
      chk("rdata", bus.rnd_data, m_rdata);
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic cpu_write(input logic [3:0] a, input logic [7:0] d);
    bus.cpu_wr = 1'b1; bus.cpu_addr = a; bus.cpu_din = d;
    tick();
    bus.cpu_wr = 1'b0; bus.cpu_din = 8'h00; bus.cpu_addr = 4'h0;
  endtask

  task automatic wait_enn_high();
    int n = 0;
    while (bus.poly_enn !== 1'b1 && n < CLK_DIV + 2) begin tick(); n++; end
    chk("enn_wait_timeout", {7'd0, bus.poly_enn}, 8'd1);
  endtask

  // Counts visible ticks from the current falling edge; stops just after the nth is consumed.
  task automatic count_pulses(input int want);
    int got = 0;
    int n = 0;
    while (got < want && n < (want + 2) * CLK_DIV) begin
      if (bus.poly_enn === 1'b1) got++;
      tick(); n++;
    end
    chk("pulse_wait_timeout", 8'(got), 8'(want));
  endtask

  task automatic count_until_run(output int pulses);
    int n = 0;
    pulses = 0;
    while (bus.poly_init === 1'b1 && n < (INIT_TICKS + 4) * CLK_DIV) begin
      if (bus.poly_enn === 1'b1) pulses++;
      tick(); n++;
    end
  endtask

  initial begin
    int p;
    bus.cpu_wr = 1'b0; bus.cpu_addr = 4'h0; bus.cpu_din = 8'h00;
    bus.rnd_rd = 1'b0; bus.poly_rnd = 8'h00;
    tick(); tick(); tick();
    cmp_en = 1'b1;
    chk("rst_enn",   {7'd0, bus.poly_enn},   8'd0);
    chk("rst_init",  {7'd0, bus.poly_init},  8'd1);
    chk("rst_ready", {7'd0, bus.poly_ready}, 8'd0);
    chk("rst_sel9",  {7'd0, bus.poly_sel9},  8'd0);
    chk("rst_rvld",  {7'd0, bus.rnd_valid},  8'd0);
    chk("rst_rdata", bus.rnd_data, 8'h00);
    reset = 1'b0;

    // Prescaler period
    for (int i = 1; i <= 33; i++) begin
      tick();
      if (i == 15 || i == 17 || i == 31) chk("enn_low", {7'd0, bus.poly_enn}, 8'd0);
      if (i == 16 || i == 32)            chk("enn_high", {7'd0, bus.poly_enn}, 8'd1);
    end
    chk("hold_init", {7'd0, bus.poly_init}, 8'd1);

    // Release init: 17 ticks of flush
    tick(); tick();
    cpu_write(4'hF, 8'h03);
    count_until_run(p);
    chk("flush_ticks", 8'(p), 8'd17);
    chk("run_ready", {7'd0, bus.poly_ready}, 8'd1);
    chk("run_init",  {7'd0, bus.poly_init},  8'd0);

    // Abort flush after 10 ticks, then a full flush is needed again
    cpu_write(4'hF, 8'h00);
    chk("hold_again", {7'd0, bus.poly_ready}, 8'd0);
    cpu_write(4'hF, 8'h03);
    count_pulses(10);
    cpu_write(4'hF, 8'h00);
    chk("abort_init", {7'd0, bus.poly_init}, 8'd1);
    cpu_write(4'hF, 8'h03);
    count_until_run(p);
    chk("reflush_ticks", 8'(p), 8'd17);

    // Nonzero rewrite in FLUSH does not restart the count
    cpu_write(4'hF, 8'h00);
    cpu_write(4'hF, 8'h03);
    count_pulses(5);
    cpu_write(4'hF, 8'h02);
    count_until_run(p);
    chk("no_restart_ticks", 8'(p), 8'd12);

    // Zero write coincident with the final tick wins
    cpu_write(4'hF, 8'h00);
    cpu_write(4'hF, 8'h01);
    count_pulses(16);
    wait_enn_high();
    cpu_write(4'hF, 8'h00);
    chk("coinc_init",  {7'd0, bus.poly_init},  8'd1);
    chk("coinc_ready", {7'd0, bus.poly_ready}, 8'd0);
    cpu_write(4'hF, 8'h03);
    count_until_run(p);
    chk("final_flush_ticks", 8'(p), 8'd17);

    // sel9 follows AUDCTL only at tick boundaries
    repeat (4) tick();
    cpu_write(4'h8, 8'h80);
    chk("sel9_midtick", {7'd0, bus.poly_sel9}, 8'd0);
    wait_enn_high();
    chk("sel9_at_enn", {7'd0, bus.poly_sel9}, 8'd0);
    tick();
    chk("sel9_after_enn", {7'd1 & 7'd0, bus.poly_sel9}, 8'd1);
    repeat (3) tick();
    cpu_write(4'h8, 8'h80);
    cpu_write(4'h8, 8'h00);
    cpu_write(4'h9, 8'h80);
    wait_enn_high();
    tick();
    chk("sel9_last_wins", {7'd0, bus.poly_sel9}, 8'd0);
    cpu_write(4'h8, 8'h80);
    wait_enn_high();
    tick();
    chk("sel9_set", {7'd0, bus.poly_sel9}, 8'd1);

    // RANDOM reads in RUN
    bus.poly_rnd = 8'h5A; bus.rnd_rd = 1'b1;
    tick();
    bus.rnd_rd = 1'b0;
    chk("rd_data", bus.rnd_data, 8'h5A);
    chk("rd_vld",  {7'd0, bus.rnd_valid}, 8'd1);
    tick();
    chk("rd_vld_drop", {7'd0, bus.rnd_valid}, 8'd0);
    bus.poly_rnd = 8'h11; bus.rnd_rd = 1'b1;
    tick();
    chk("rd_b2b_0", bus.rnd_data, 8'h11);
    bus.poly_rnd = 8'h22;
    tick();
    bus.rnd_rd = 1'b0;
    chk("rd_b2b_1", bus.rnd_data, 8'h22);
    chk("rd_b2b_vld", {7'd0, bus.rnd_valid}, 8'd1);
    wait_enn_high();
    bus.poly_rnd = 8'h33; bus.rnd_rd = 1'b1;
    tick();
    bus.rnd_rd = 1'b0; bus.poly_rnd = 8'h44;
    chk("rd_at_enn", bus.rnd_data, 8'h33);

    // Reset in RUN with sel9 set and a read in flight
    tick();
    bus.poly_rnd = 8'h77; bus.rnd_rd = 1'b1; reset = 1'b1;
    tick();
    bus.rnd_rd = 1'b0;
    chk("mid_rst_enn",   {7'd0, bus.poly_enn},   8'd0);
    chk("mid_rst_init",  {7'd0, bus.poly_init},  8'd1);
    chk("mid_rst_ready", {7'd0, bus.poly_ready}, 8'd0);
    chk("mid_rst_sel9",  {7'd0, bus.poly_sel9},  8'd0);
    chk("mid_rst_rvld",  {7'd0, bus.rnd_valid},  8'd0);
    chk("mid_rst_rdata", bus.rnd_data, 8'h00);
    tick();
    reset = 1'b0;

    // Read in HOLD, and pending sel9 discarded by reset
    bus.poly_rnd = 8'h5A; bus.rnd_rd = 1'b1;
    tick();
    bus.rnd_rd = 1'b0;
    chk("hold_rd_data", bus.rnd_data, 8'hFF);
    chk("hold_rd_vld",  {7'd0, bus.rnd_valid}, 8'd1);
    wait_enn_high();
    tick();
    chk("sel9_discarded", {7'd0, bus.poly_sel9}, 8'd0);

    repeat (3) tick();
    cmp_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
